hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
- Sequences all writes into the HI/LO register pair for the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and runs an iterative radix-2 divider and a single-cycle-registered multiplier.
- Drives the HI/LO write enables and data, and tells the pipeline to stall while an operation is in flight.
- Sits between the EX stage and the HI/LO register file.

Parameters:
DATA_W, 32, operand and HI/LO width; the divider iterates DATA_W cycles.

Ports:
clk  in  1  clock; all state changes on posedge.
resetn  in  1  asynchronous active-low reset.
op_valid  in  1  EX presents an operation this cycle.
op_code  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are ignored (no accept).
src_a  in  DATA_W  rs operand (dividend, multiplicand, or MTHI/MTLO data).
src_b  in  DATA_W  rt operand (divisor or multiplier).
flush  in  1  synchronous pipeline flush (exception or branch squash).
op_ready  out  1  high only in IDLE; an op is accepted when op_valid & op_ready & !flush & op_code<6.
stall_req  out  1  = (state!=IDLE) | (op_valid & !flush & op_code<4).
hi_we  out  1  registered one-cycle HI write enable.
hi_wdata  out  DATA_W  registered HI write data.
lo_we  out  1  registered one-cycle LO write enable.
lo_wdata  out  DATA_W  registered LO write data.
done  out  1  one-cycle pulse, coincident with the write cycle.

Behaviour:
- Reset (async, resetn=0): state=IDLE; counter=0; hi_we=lo_we=done=0; hi_wdata=lo_wdata=0; op_ready=1; stall_req follows its equation.
- States: IDLE, MUL, DIV, FIX, WB.
- IDLE transitions on accept:
  - MULT/MULTU go to MUL; operands are latched.
  - DIV/DIVU go to DIV; the magnitudes of the operands are latched (abs for DIV, raw for DIVU), the sign flags are latched, and the counter is cleared.
  - MTHI goes to WB with hi_wdata=src_a; hi_we only.
  - MTLO goes to WB with lo_wdata=src_a; lo_we only.
- MUL (1 cycle): 2*DATA_W product is signed for MULT and unsigned for MULTU. {hi_wdata,lo_wdata} are loaded with the product, and the state goes to WB.
- DIV: one restoring-division step per cycle, DATA_W cycles total. The counter increments each cycle; after the cycle with counter==DATA_W-1 the state goes to FIX.
- FIX (1 cycle):
  - For DIV, the quotient is negated if the operand signs differ, and the remainder takes the dividend's sign.
  - lo_wdata is loaded with the quotient and hi_wdata with the remainder, then the state goes to WB.
  - Divisor==0 (either signedness) gives hi_wdata=src_a and lo_wdata=0xFFFFFFFF, with no sign fixup. The full DATA_W cycles are still taken.
- WB (1 cycle): the selected we outputs and done are 1. For MUL/DIV both hi_we and lo_we are 1. Next state is IDLE. The wdata registers hold their values until the next load.
- Latency from the accept cycle T:
  - MTHI/MTLO write at T+1.
  - MULT/MULTU write at T+2.
  - DIV/DIVU write at T+DATA_W+2, i.e. T+34.
  - The earliest next accept is the cycle after WB.
- flush in MUL, DIV or FIX: the operation is abandoned and the state goes to IDLE next cycle; no write, no done.
- flush in WB: it does not cancel. The write in progress completes because its outputs were already registered.
- flush in IDLE: it blocks the accept.
- Reset mid-operation: immediate return to the reset values; no write.
- Signed overflow case: 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000 and HI=0. This is the natural wrap and needs no special case.
- op_valid while busy: ignored; EX holds the op because stall_req=1.

Test Plan:
- MTHI src_a=0x12345678 accepted at T -> at T+1 hi_we=1, hi_wdata=0x12345678, lo_we=0, done=1; op_ready=1 at T+2.
- MULT src_a=0xFFFFFFFE (-2), src_b=3 -> at T+2 hi_wdata=0xFFFFFFFF, lo_wdata=0xFFFFFFFA, both we=1.
  - The same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV -7/2 -> at T+34 lo_wdata=0xFFFFFFFD, hi_wdata=0xFFFFFFFF; stall_req high at T..T+34; op_ready low T+1..T+34.
- DIVU 100/0 -> at T+34 hi_wdata=100, lo_wdata=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU started at T with flush at T+10 -> IDLE at T+11; no we/done through T+40; a new MTLO accepted at T+11 writes at T+12.
- resetn pulsed low at T+5 of a DIV -> outputs are zero immediately; no write after release; op_ready=1.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hilo_muldiv_ctrl
// Description : HI/LO write sequencer for the MIPS core. Accepts
//               MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs a registered
//               multiplier or an iterative radix-2 restoring divider, and
//               issues registered one-cycle HI/LO writes. Requests a pipeline
//               stall while an operation is in flight.
// Ports       : clk, resetn (async, active low)
//               op_valid, op_code[2:0], src_a, src_b, flush   (from EX)
//               op_ready, stall_req                          (to pipeline)
//               hi_we, hi_wdata, lo_we, lo_wdata, done       (to HI/LO file)
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    output logic              op_ready,
    output logic              stall_req,
    output logic              hi_we,
    output logic [DATA_W-1:0] hi_wdata,
    output logic              lo_we,
    output logic [DATA_W-1:0] lo_wdata,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PW    = 2 * DATA_W + 2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;        // raw src_a (multiplicand / dividend)
    logic [DATA_W-1:0] b_q, b_d;        // multiplier, or divisor magnitude
    logic              sgn_q, sgn_d;    // signed multiply
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quot_q, quot_d;  // dividend magnitude shifting out, quotient in
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              hi_we_q, hi_we_d;
    logic              lo_we_q, lo_we_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] hi_wdata_q, hi_wdata_d;
    logic [DATA_W-1:0] lo_wdata_q, lo_wdata_d;

    logic              w_accept;
    logic              w_div_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W:0]   w_diff;
    logic              w_ge;
    logic signed [DATA_W:0] w_ma;
    logic signed [DATA_W:0] w_mb;
    logic signed [PW-1:0]   w_prod;

    assign op_ready  = (state_q == S_IDLE);
    assign stall_req = (state_q != S_IDLE) | (op_valid & ~flush & (op_code < OP_MTHI));
    assign w_accept  = op_valid & op_ready & ~flush & (op_code <= OP_MTLO);

    assign hi_we    = hi_we_q;
    assign lo_we    = lo_we_q;
    assign done     = done_q;
    assign hi_wdata = hi_wdata_q;
    assign lo_wdata = lo_wdata_q;

    // Operand magnitudes for the divider (DIVU keeps raw operands)
    assign w_div_signed = (op_code == OP_DIV);
    assign w_a_neg      = w_div_signed & src_a[DATA_W-1];
    assign w_b_neg      = w_div_signed & src_b[DATA_W-1];
    assign w_a_mag      = w_a_neg ? -src_a : src_a;
    assign w_b_mag      = w_b_neg ? -src_b : src_b;

    // Restoring step: shift next dividend bit into the partial remainder and
    // trial-subtract; the top bit of the (DATA_W+1)-bit difference is the borrow.
    assign w_rem_sh = {rem_q, quot_q[DATA_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, b_q};
    assign w_ge     = ~w_diff[DATA_W];

    // One extra bit per operand lets a single signed multiplier serve MULTU
    assign w_ma   = {sgn_q & a_q[DATA_W-1], a_q};
    assign w_mb   = {sgn_q & b_q[DATA_W-1], b_q};
    assign w_prod = PW'(w_ma) * PW'(w_mb);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        sgn_d      = sgn_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        hi_we_d    = 1'b0;
        lo_we_d    = 1'b0;
        done_d     = 1'b0;
        hi_wdata_d = hi_wdata_q;
        lo_wdata_d = lo_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_code)
                        OP_MULT, OP_MULTU: begin
                            a_d     = src_a;
                            b_d     = src_b;
                            sgn_d   = (op_code == OP_MULT);
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = src_a;
                            b_d     = w_b_mag;
                            quot_d  = w_a_mag;
                            rem_d   = '0;
                            cnt_d   = '0;
                            negq_d  = w_a_neg ^ w_b_neg;
                            negr_d  = w_a_neg;
                            state_d = S_DIV;
                        end
                        OP_MTHI: begin
                            hi_wdata_d = src_a;
                            hi_we_d    = 1'b1;
                            done_d     = 1'b1;
                            state_d    = S_WB;
                        end
                        OP_MTLO: begin
                            lo_wdata_d = src_a;
                            lo_we_d    = 1'b1;
                            done_d     = 1'b1;
                            state_d    = S_WB;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_wdata_d = w_prod[2*DATA_W-1:DATA_W];
                    lo_wdata_d = w_prod[DATA_W-1:0];
                    hi_we_d    = 1'b1;
                    lo_we_d    = 1'b1;
                    done_d     = 1'b1;
                    state_d    = S_WB;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d  = w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
                    quot_d = {quot_q[DATA_W-2:0], w_ge};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    // Divide by zero: HI returns the dividend, LO all ones
                    if (b_q == '0) begin
                        hi_wdata_d = a_q;
                        lo_wdata_d = '1;
                    end else begin
                        hi_wdata_d = negr_q ? -rem_q : rem_q;
                        lo_wdata_d = negq_q ? -quot_q : quot_q;
                    end
                    hi_we_d = 1'b1;
                    lo_we_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // Write outputs are already registered; flush cannot cancel here
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sgn_q      <= 1'b0;
            rem_q      <= '0;
            quot_q     <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            hi_we_q    <= 1'b0;
            lo_we_q    <= 1'b0;
            done_q     <= 1'b0;
            hi_wdata_q <= '0;
            lo_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sgn_q      <= sgn_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            hi_we_q    <= hi_we_d;
            lo_we_q    <= lo_we_d;
            done_q     <= done_d;
            hi_wdata_q <= hi_wdata_d;
            lo_wdata_q <= lo_wdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_muldiv_ctrl
// Description : Directed self-checking bench for hilo_muldiv_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_muldiv_ctrl;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        op_ready;
    logic        stall_req;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        lo_we;
    logic [31:0] lo_wdata;
    logic        done;

    int total = 0;
    int bad   = 0;

    hilo_muldiv_ctrl #(.DATA_W(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .op_valid  (op_valid),
        .op_code   (op_code),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .op_ready  (op_ready),
        .stall_req (stall_req),
        .hi_we     (hi_we),
        .hi_wdata  (hi_wdata),
        .lo_we     (lo_we),
        .lo_wdata  (lo_wdata),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present an op at the negedge of cycle T, hold it over the accept edge,
    // then drop op_valid. The next negedge is inside cycle T+1.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = op;
        src_a    = a;
        src_b    = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; op_valid = 1'b0; op_code = 3'd0; src_a = '0; src_b = '0; flush = 1'b0;
        #2;
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_op_ready got=%b exp=1", op_ready); end
        total++; if ({hi_we, lo_we, done} !== 3'b000) begin bad++; $display("FAIL reset_we got=%b exp=000", {hi_we, lo_we, done}); end
        total++; if (hi_wdata !== 32'h0 || lo_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h/%h exp=0/0", hi_wdata, lo_wdata); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall_idle got=%b exp=0", stall_req); end
        op_valid = 1'b1; op_code = OP_DIV; #1;
        total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL reset_stall_div got=%b exp=1", stall_req); end
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_mthi;
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_MTHI; src_a = 32'h12345678; src_b = 32'h0;
        #1;
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL mthi_stall got=%b exp=0", stall_req); end
        @(posedge clk); #1; op_valid = 1'b0;
        @(negedge clk);
        total++; if ({hi_we, lo_we, done} !== 3'b101 || hi_wdata !== 32'h12345678) begin
            bad++; $display("FAIL mthi_write we/lo/done=%b hi=%h exp=101 12345678", {hi_we, lo_we, done}, hi_wdata);
        end
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%b exp=0", op_ready); end
        @(negedge clk);
        total++; if (op_ready !== 1'b1 || done !== 1'b0 || hi_we !== 1'b0) begin
            bad++; $display("FAIL mthi_after rdy=%b done=%b hi_we=%b exp=1 0 0", op_ready, done, hi_we);
        end
        total++; if (hi_wdata !== 32'h12345678) begin bad++; $display("FAIL mthi_hold got=%h exp=12345678", hi_wdata); end
    endtask

    task automatic test_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(op, a, b);
        @(negedge clk);
        total++; if (done !== 1'b0 || op_ready !== 1'b0 || stall_req !== 1'b1) begin
            bad++; $display("FAIL mul_t1 op=%0d done=%b rdy=%b stall=%b exp=0 0 1", op, done, op_ready, stall_req);
        end
        @(negedge clk);
        total++; if ({hi_we, lo_we, done} !== 3'b111 || hi_wdata !== exp_hi || lo_wdata !== exp_lo) begin
            bad++; $display("FAIL mul_t2 op=%0d we=%b hi=%h lo=%h exp=111 %h %h", op, {hi_we, lo_we, done}, hi_wdata, lo_wdata, exp_hi, exp_lo);
        end
        @(negedge clk);
    endtask

    task automatic test_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int early;
        early = 0;
        @(negedge clk);
        op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
        #1;
        total++; if (stall_req !== 1'b1 || op_ready !== 1'b1) begin
            bad++; $display("FAIL div_t0 stall=%b rdy=%b exp=1 1", stall_req, op_ready);
        end
        @(posedge clk); #1; op_valid = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (stall_req !== 1'b1 || op_ready !== 1'b0 || done !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL div_busy a=%h b=%h bad_cycles=%0d exp=0", a, b, early); end
        @(negedge clk);
        total++; if ({hi_we, lo_we, done} !== 3'b111 || hi_wdata !== exp_hi || lo_wdata !== exp_lo) begin
            bad++; $display("FAIL div_t34 a=%h b=%h we=%b hi=%h lo=%h exp=111 %h %h", a, b, {hi_we, lo_we, done}, hi_wdata, lo_wdata, exp_hi, exp_lo);
        end
        total++; if (stall_req !== 1'b1 || op_ready !== 1'b0) begin
            bad++; $display("FAIL div_t34_stall stall=%b rdy=%b exp=1 0", stall_req, op_ready);
        end
        @(negedge clk);
        total++; if (op_ready !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL div_t35 rdy=%b done=%b exp=1 0", op_ready, done);
        end
    endtask

    task automatic test_flush_div;
        int spurious;
        spurious = 0;
        issue(OP_DIVU, 32'd1000, 32'd7);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0) spurious++;
        end
        @(negedge clk);            // T+10
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);            // T+11
        total++; if (op_ready !== 1'b1 || stall_req !== 1'b0) begin
            bad++; $display("FAIL flush_idle rdy=%b stall=%b exp=1 0", op_ready, stall_req);
        end
        op_valid = 1'b1; op_code = OP_MTLO; src_a = 32'hCAFEF00D;
        @(posedge clk); #1; op_valid = 1'b0;
        @(negedge clk);            // T+12
        total++; if ({hi_we, lo_we, done} !== 3'b011 || lo_wdata !== 32'hCAFEF00D) begin
            bad++; $display("FAIL flush_mtlo we=%b lo=%h exp=011 cafef00d", {hi_we, lo_we, done}, lo_wdata);
        end
        for (int k = 13; k <= 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0) spurious++;
        end
        total++; if (spurious != 0) begin bad++; $display("FAIL flush_no_write bad_cycles=%0d exp=0", spurious); end
    endtask

    task automatic test_flush_idle_and_bad_op;
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_DIV; src_a = 32'd9; src_b = 32'd3; flush = 1'b1;
        #1;
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b exp=0", stall_req); end
        @(posedge clk); #1; op_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL flush_idle_block rdy=%b exp=1", op_ready); end
        issue(3'd6, 32'hFFFF0000, 32'd1);
        @(negedge clk);
        total++; if (op_ready !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL opcode6 rdy=%b done=%b exp=1 0", op_ready, done);
        end
    endtask

    task automatic test_flush_in_wb;
        issue(OP_MTLO, 32'h0BADBEEF, 32'd0);
        @(negedge clk);            // T+1, WB
        flush = 1'b1;
        #1;
        total++; if ({hi_we, lo_we, done} !== 3'b011 || lo_wdata !== 32'h0BADBEEF) begin
            bad++; $display("FAIL flush_wb we=%b lo=%h exp=011 0badbeef", {hi_we, lo_we, done}, lo_wdata);
        end
        @(posedge clk); #1; flush = 1'b0;
    endtask

    task automatic test_back_to_back;
        issue(OP_MTHI, 32'hAAAA5555, 32'd0);
        op_valid = 1'b1; op_code = OP_MTLO; src_a = 32'h5555AAAA;   // held while busy
        @(negedge clk);            // T+1 WB: not accepted
        total++; if (op_ready !== 1'b0 || stall_req !== 1'b1) begin
            bad++; $display("FAIL b2b_busy rdy=%b stall=%b exp=0 1", op_ready, stall_req);
        end
        @(posedge clk); #1;        // T+2 IDLE: accepted at end of this cycle
        @(posedge clk); #1; op_valid = 1'b0;
        @(negedge clk);            // T+3
        total++; if ({hi_we, lo_we, done} !== 3'b011 || lo_wdata !== 32'h5555AAAA || hi_wdata !== 32'hAAAA5555) begin
            bad++; $display("FAIL b2b_write we=%b hi=%h lo=%h exp=011 aaaa5555 5555aaaa", {hi_we, lo_we, done}, hi_wdata, lo_wdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_div;
        int spurious;
        spurious = 0;
        issue(OP_DIV, 32'd50, 32'd5);
        repeat (4) @(negedge clk);  // T+4
        @(negedge clk);             // T+5
        resetn = 1'b0;
        #1;
        total++; if (op_ready !== 1'b1 || {hi_we, lo_we, done} !== 3'b000 || hi_wdata !== 32'h0 || lo_wdata !== 32'h0) begin
            bad++; $display("FAIL rst_mid rdy=%b we=%b hi=%h lo=%h exp=1 000 0 0", op_ready, {hi_we, lo_we, done}, hi_wdata, lo_wdata);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || hi_we !== 1'b0 || lo_we !== 1'b0 || op_ready !== 1'b1) spurious++;
        end
        total++; if (spurious != 0) begin bad++; $display("FAIL rst_mid_quiet bad_cycles=%0d exp=0", spurious); end
    endtask

    initial begin
        test_reset();
        test_mthi();
        test_mul(OP_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        test_mul(OP_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
        test_mul(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        test_div(OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        test_div(OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
        test_div(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        test_div(OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC);
        test_div(OP_DIV,  32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        test_flush_div();
        test_flush_idle_and_bad_op();
        test_flush_in_wb();
        test_back_to_back();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
